// File: rtl/l2_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_bus_pkg : shared op/snoop codes, FSM states and FIFO entry layout  |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package l2_bus_pkg;

  localparam logic [2:0] c_op_read  = 3'd1;
  localparam logic [2:0] c_op_write = 3'd2;
  localparam logic [2:0] c_op_inval = 3'd3;
  localparam logic [2:0] c_op_rwim  = 3'd4;

  localparam logic [1:0] c_snp_hit   = 2'd0;
  localparam logic [1:0] c_snp_hitm  = 2'd1;
  localparam logic [1:0] c_snp_nohit = 2'd2;

  localparam int unsigned c_addr_w = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_SNOOP = 3'd2,
    ST_XFER  = 3'd3,
    ST_RESP  = 3'd4
  } l2_bus_state_e;

  // Entry layout at the default address width; the FIFO stores {op, addr}.
  typedef struct packed {
    logic [2:0]          op;
    logic [c_addr_w-1:0] addr;
  } l2_bus_entry_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op >= c_op_read) && (op <= c_op_rwim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_bus_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_bus_fifo : synchronous request FIFO, DEPTH entries (power of two)  |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module l2_bus_fifo #(
  parameter  int unsigned WIDTH = 35,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_bus_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_bus_if : queues L2 bus ops, runs them on the system bus one at a   |
// |             time and returns the snoop result.   Revision : 1.0      |
// +----------------------------------------------------------------------+
module l2_bus_if
  import l2_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned OFFSET_W   = 6,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SNOOP_WAIT = 2,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [2:0]        rsp_op,
  output logic [1:0]        rsp_snoop,
  output logic              rsp_err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [1:0]        bus_snoop,
  input  logic              bus_done,
  output logic [15:0]       ops_issued,
  output logic [15:0]       hitm_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = 3 + ADDR_W;

  localparam logic [CNT_W-1:0]  c_depth      = CNT_W'(DEPTH);
  localparam logic [2:0]        c_snoop_load = 3'(SNOOP_WAIT);
  localparam logic [7:0]        c_tcnt_last  = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] c_line_mask  = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  l2_bus_state_e     r_state;
  l2_bus_state_e     w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic [7:0]        r_tcnt;
  logic [7:0]        w_tcnt_nxt;
  logic [1:0]        r_snoop;
  logic [1:0]        w_snoop_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic [15:0]       r_ops;
  logic [15:0]       r_hitm;
  logic              w_issue;
  logic              w_hitm;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_head;
  logic [2:0]        w_head_op;
  logic [ADDR_W-1:0] w_head_addr;
  logic [ADDR_W-1:0] w_line_addr;
  logic [1:0]        w_snoop_norm;

  // Readiness reflects occupancy only, so a pop in RESP never frees a slot early.
  assign req_ready    = (w_count < c_depth);
  assign w_push       = req_valid & ~w_full;
  assign w_head_op    = w_head[ENT_W-1:ADDR_W];
  assign w_head_addr  = w_head[ADDR_W-1:0];
  assign w_line_addr  = w_head_addr & c_line_mask;
  assign w_snoop_norm = (bus_snoop == 2'b11) ? c_snp_nohit : bus_snoop;
  assign ops_issued   = r_ops;
  assign hitm_count   = r_hitm;

  l2_bus_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({req_op, req_addr}),
    .pop       (w_pop),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_snoop <= '0;
      r_err   <= 1'b0;
      r_ops   <= '0;
      r_hitm  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_snoop <= w_snoop_nxt;
      r_err   <= w_err_nxt;
      if (w_issue && (r_ops != 16'hFFFF))  r_ops  <= r_ops + 16'd1;
      if (w_hitm && (r_hitm != 16'hFFFF))  r_hitm <= r_hitm + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tcnt_nxt  = r_tcnt;
    w_snoop_nxt = r_snoop;
    w_err_nxt   = r_err;
    w_issue     = 1'b0;
    w_hitm      = 1'b0;
    w_pop       = 1'b0;
    bus_req     = 1'b0;
    bus_op      = '0;
    bus_addr    = '0;
    rsp_valid   = 1'b0;
    rsp_op      = '0;
    rsp_snoop   = '0;
    rsp_err     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_snoop_nxt = c_snp_nohit;
          w_err_nxt   = 1'b0;
          if (!op_is_legal(w_head_op)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_ARB;
          end
        end
      end

      ST_ARB: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          w_cnt_nxt   = c_snoop_load;
          w_issue     = 1'b1;
          w_state_nxt = ST_SNOOP;
        end
      end

      ST_SNOOP: begin
        bus_req   = 1'b1;
        bus_op    = w_head_op;
        bus_addr  = w_line_addr;
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_snoop_nxt = w_snoop_norm;
          w_hitm      = (w_snoop_norm == c_snp_hitm);
          w_tcnt_nxt  = '0;
          w_state_nxt = (w_head_op == c_op_inval) ? ST_RESP : ST_XFER;
        end
      end

      ST_XFER: begin
        bus_req  = 1'b1;
        bus_op   = w_head_op;
        bus_addr = w_line_addr;
        // A completion arriving in the last allowed cycle still counts as success.
        if (bus_done) begin
          w_state_nxt = ST_RESP;
        end else if (r_tcnt == c_tcnt_last) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_tcnt_nxt = r_tcnt + 8'd1;
        end
      end

      ST_RESP: begin
        rsp_valid   = 1'b1;
        rsp_op      = w_head_op;
        rsp_snoop   = r_snoop;
        rsp_err     = r_err;
        w_pop       = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_bus_if.sv
`default_nettype none
// Directed self-checking bench for l2_bus_if with hand-computed expectations.
module tb_l2_bus_if;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [2:0]  rsp_op;
  logic [1:0]  rsp_snoop;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_gnt;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic [1:0]  bus_snoop;
  logic        bus_done;
  logic [15:0] ops_issued;
  logic [15:0] hitm_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rsp_pulses = 0;
  int req_rises  = 0;
  logic prev_req = 1'b0;

  logic       got_rsp;
  int         rsp_cyc;
  logic [2:0] s_op;
  logic [1:0] s_snoop;
  logic       s_err;

  l2_bus_if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_op     (rsp_op),
    .rsp_snoop  (rsp_snoop),
    .rsp_err    (rsp_err),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_op     (bus_op),
    .bus_addr   (bus_addr),
    .bus_snoop  (bus_snoop),
    .bus_done   (bus_done),
    .ops_issued (ops_issued),
    .hitm_count (hitm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rsp_valid) rsp_pulses++;
    if (bus_req && !prev_req) req_rises++;
    prev_req = bus_req;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] addr);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(input string tag, input int max);
    got_rsp = 1'b0;
    for (int i = 0; i < max && !got_rsp; i++) begin
      tick();
      if (rsp_valid) begin
        got_rsp = 1'b1;
        rsp_cyc = cyc;
        s_op    = rsp_op;
        s_snoop = rsp_snoop;
        s_err   = rsp_err;
      end
    end
    check_eq({tag, "_seen"}, {31'd0, got_rsp}, 32'd1);
  endtask

  logic [2:0] burst_ops [5] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2};
  int p;
  int base;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
    bus_gnt = 1'b0; bus_snoop = '0; bus_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_ready",  {31'd0, req_ready}, 32'd1);
    check_eq("rst_busreq", {31'd0, bus_req},   32'd0);
    check_eq("rst_rspv",   {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_busop",  {29'd0, bus_op},    32'd0);
    check_eq("rst_ops",    {16'd0, ops_issued}, 32'd0);
    check_eq("rst_hitm",   {16'd0, hitm_count}, 32'd0);

    // READ with HITM, done on first XFER cycle
    bus_gnt = 1'b1; bus_snoop = 2'd1; bus_done = 1'b1;
    push(3'd1, 32'h0000_1234);
    p = cyc;
    check_eq("rd_idle_noreq", {31'd0, bus_req}, 32'd0);
    tick();
    check_eq("rd_arb_req",   {31'd0, bus_req}, 32'd1);
    check_eq("rd_arb_busop", {29'd0, bus_op},  32'd0);
    tick();
    check_eq("rd_busop",   {29'd0, bus_op}, 32'd1);
    check_eq("rd_busaddr", bus_addr,        32'h0000_1200);
    wait_rsp("rd", 20);
    check_eq("rd_latency", rsp_cyc - p,       32'd5);
    check_eq("rd_rspop",   {29'd0, s_op},     32'd1);
    check_eq("rd_snoop",   {30'd0, s_snoop},  32'd1);
    check_eq("rd_err",     {31'd0, s_err},    32'd0);
    check_eq("rd_hitm",    {16'd0, hitm_count}, 32'd1);
    check_eq("rd_ops",     {16'd0, ops_issued}, 32'd1);

    // INVALIDATE skips XFER
    bus_snoop = 2'd0;
    push(3'd3, 32'hABCD_0040);
    p = cyc;
    wait_rsp("inv", 20);
    check_eq("inv_latency", rsp_cyc - p,      32'd4);
    check_eq("inv_rspop",   {29'd0, s_op},    32'd3);
    check_eq("inv_snoop",   {30'd0, s_snoop}, 32'd0);
    check_eq("inv_err",     {31'd0, s_err},   32'd0);
    check_eq("inv_hitm",    {16'd0, hitm_count}, 32'd1);

    // Fill the FIFO with the bus withheld; snoop 2'b11 reads back as NOHIT
    reset_dut();
    bus_gnt = 1'b0; bus_snoop = 2'b11; bus_done = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_op   = burst_ops[i];
      req_addr = 32'h1000_0000 + 32'(i * 64);
      tick();
      if (i == 2) check_eq("burst_ready3", {31'd0, req_ready}, 32'd1);
      if (i == 3) check_eq("burst_full4",  {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    check_eq("burst_full5", {31'd0, req_ready}, 32'd0);
    base = rsp_pulses;
    bus_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rsp("burst", 20);
      check_eq("burst_op",    {29'd0, s_op},    {29'd0, burst_ops[i]});
      check_eq("burst_snoop", {30'd0, s_snoop}, 32'd2);
    end
    repeat (12) tick();
    check_eq("burst_count", rsp_pulses - base, 32'd4);
    check_eq("burst_ops",   {16'd0, ops_issued}, 32'd4);
    check_eq("burst_ready", {31'd0, req_ready},  32'd1);

    // Illegal op between two READs
    reset_dut();
    bus_gnt = 1'b1; bus_snoop = 2'd0; bus_done = 1'b1;
    base = req_rises;
    push(3'd1, 32'h0000_0100);
    push(3'd7, 32'h0000_0200);
    push(3'd1, 32'h0000_0300);
    wait_rsp("ill0", 20);
    check_eq("ill0_err", {31'd0, s_err}, 32'd0);
    wait_rsp("ill1", 20);
    check_eq("ill1_err",   {31'd0, s_err},   32'd1);
    check_eq("ill1_op",    {29'd0, s_op},    32'd7);
    check_eq("ill1_snoop", {30'd0, s_snoop}, 32'd2);
    wait_rsp("ill2", 20);
    check_eq("ill2_err", {31'd0, s_err}, 32'd0);
    check_eq("ill_reqs", req_rises - base, 32'd2);
    check_eq("ill_ops",  {16'd0, ops_issued}, 32'd2);

    // Timeout, then the queued WRITE completes normally
    reset_dut();
    bus_gnt = 1'b1; bus_snoop = 2'd0; bus_done = 1'b0;
    push(3'd1, 32'h8000_0000);
    p = cyc;
    push(3'd2, 32'h8000_0100);
    wait_rsp("tmo", 40);
    check_eq("tmo_latency", rsp_cyc - p,   32'd19);
    check_eq("tmo_err",     {31'd0, s_err}, 32'd1);
    check_eq("tmo_op",      {29'd0, s_op},  32'd1);
    bus_done = 1'b1;
    p = rsp_cyc;
    wait_rsp("tmo_next", 20);
    check_eq("tmo_next_lat", rsp_cyc - p,   32'd6);
    check_eq("tmo_next_err", {31'd0, s_err}, 32'd0);
    check_eq("tmo_next_op",  {29'd0, s_op},  32'd2);

    // Reset in the middle of XFER with three ops queued
    reset_dut();
    bus_gnt = 1'b1; bus_snoop = 2'd1; bus_done = 1'b0;
    base = rsp_pulses;
    push(3'd1, 32'h0000_4000);
    push(3'd2, 32'h0000_5000);
    push(3'd1, 32'h0000_6000);
    tick(); tick(); tick();
    check_eq("mid_busreq", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mrst_busreq", {31'd0, bus_req},    32'd0);
    check_eq("mrst_ready",  {31'd0, req_ready},  32'd1);
    check_eq("mrst_ops",    {16'd0, ops_issued}, 32'd0);
    check_eq("mrst_hitm",   {16'd0, hitm_count}, 32'd0);
    check_eq("mrst_rspv",   {31'd0, rsp_valid},  32'd0);
    repeat (5) tick();
    check_eq("mrst_norsp",   rsp_pulses - base,  32'd0);
    check_eq("mrst_idlereq", {31'd0, bus_req},   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_bus_if.md
Name: l2_bus_if

Overview:
Downstream stage of the L2 cache model. It accepts bus operations (READ, WRITE, INVALIDATE, RWIM) issued by the L2 on a miss, eviction or upgrade, and queues them in a small FIFO. It arbitrates for the shared system bus, drives each operation, samples the snoop result from other caches, waits for data completion, and returns the snoop result to the L2 for its MESI update. It also keeps issue and HITM statistics.

Parameters:
ADDR_W, 32, address width
OFFSET_W, 6, line-offset bits zeroed on bus_addr (64 B line)
DEPTH, 4, request FIFO entries (power of 2)
SNOOP_WAIT, 2, cycles after grant before bus_snoop is sampled (1..7)
TIMEOUT, 15, max cycles waiting for bus_done (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
req_valid  in  1  L2 presents a bus operation
req_ready  out  1  FIFO can accept; equals (count < DEPTH)
req_op  in  3  1=READ 2=WRITE 3=INVALIDATE 4=RWIM; others illegal
req_addr  in  ADDR_W  full address
rsp_valid  out  1  one-cycle pulse: head operation complete
rsp_op  out  3  op of completed entry
rsp_snoop  out  2  0=HIT 1=HITM 2=NOHIT
rsp_err  out  1  valid with rsp_valid: illegal op or timeout
bus_req  out  1  bus request
bus_gnt  in  1  bus grant
bus_op  out  3  op driven on bus; 0 when not owning bus
bus_addr  out  ADDR_W  line-aligned address; 0 when not owning bus
bus_snoop  in  2  snoop result from other caches
bus_done  in  1  transfer complete
ops_issued  out  16  ops that reached the bus, saturating
hitm_count  out  16  HITM results sampled, saturating

Behaviour:
- Reset (rst_n=0 at posedge): FIFO emptied; state IDLE; all outputs 0 except req_ready=1; counters 0. Reset mid-operation aborts it with no rsp_valid.
- Push on req_valid && req_ready. req_ready does not depend on a same-cycle pop, so a full FIFO refuses the push even during RESP.
- FSM:
  - IDLE: if FIFO non-empty:
    - illegal head op: go to RESP with err=1 and snoop=NOHIT; no bus_req.
    - otherwise go to ARB.
  - ARB: bus_req=1 and holds until bus_gnt. On bus_gnt go to SNOOP, load cnt=SNOOP_WAIT, increment ops_issued.
  - SNOOP: bus_req=1, bus_op/bus_addr driven. cnt decrements each cycle. In the cycle cnt==1, sample bus_snoop (2'b11 is treated as NOHIT), increment hitm_count if HITM, then:
    - INVALIDATE: go to RESP.
    - all other ops: go to XFER with tcnt=0.
  - XFER: bus_req/bus_op/bus_addr held. On bus_done go to RESP. Otherwise tcnt++; when tcnt reaches TIMEOUT, go to RESP with err=1.
  - RESP: rsp_valid=1 for exactly one cycle, with rsp_op/rsp_snoop/rsp_err from the head entry. Pop the FIFO, bus_req=0, go to IDLE.
- Latency, empty FIFO, bus_gnt tied high, SNOOP_WAIT=2, bus_done in the first XFER cycle:
  - push at cycle 0; bus_req at cycle 1; SNOOP cycles 2–3; XFER cycle 4; rsp_valid at cycle 5.
- One outstanding bus op at a time; responses are returned in order.
- bus_addr = req_addr with [OFFSET_W-1:0] cleared.
- FIFO pointers wrap modulo DEPTH.
- Counters saturate at 16'hFFFF.

Decomposition:
- Package l2_bus_pkg: bus op codes (READ/WRITE/INVALIDATE/RWIM), snoop codes (HIT/HITM/NOHIT), FSM state enum, and the FIFO entry struct {op, addr}.
- Sub-module l2_bus_fifo: synchronous FIFO, DEPTH x (3+ADDR_W), with push/pop/full/empty/count.

Test Plan:
- READ 0x0000_1234, gnt high, bus_snoop=HITM, bus_done 1 cycle into XFER -> bus_addr=0x0000_1200, rsp_valid at cycle 5 with rsp_snoop=1, rsp_err=0; hitm_count=1, ops_issued=1.
- INVALIDATE 0xABCD_0040, bus_snoop=HIT -> no XFER, rsp_valid 4 cycles after push, rsp_snoop=0, rsp_op=3.
- Push 5 ops back-to-back with bus_gnt=0 -> req_ready low after 4th, 5th refused. Raise gnt -> 4 in-order responses, ops_issued=4.
- op=7 queued between two READs -> middle response has rsp_err=1, bus_req never asserted for it, ops_issued=2.
- READ with bus_done never asserted -> rsp_valid with rsp_err=1 after TIMEOUT=15 XFER cycles, then the next queued op proceeds.
- rst_n low during XFER with 3 queued -> next cycle bus_req=0, req_ready=1, counters 0, no rsp_valid.
